// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - two-requester round-robin front end for a shared combinational ALU
// Optional resp_err output enabled by defining ALU_ARBITER_ERR_EN.
module alu_arbiter #(
   parameter logic [3:0] IDLE_OP = 4'hF
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       req0_valid,
   output logic       req0_ready,
   input  logic [7:0] req0_a,
   input  logic [7:0] req0_b,
   input  logic [3:0] req0_op,
   input  logic       req1_valid,
   output logic       req1_ready,
   input  logic [7:0] req1_a,
   input  logic [7:0] req1_b,
   input  logic [3:0] req1_op,
   output logic [7:0] alu_a,
   output logic [7:0] alu_b,
   output logic [3:0] alu_op,
   input  logic [8:0] alu_z,
   output logic       resp_valid,
   output logic       resp_id,
   output logic [8:0] resp_data,
   input  logic       resp_ready,
`ifdef ALU_ARBITER_ERR_EN
   output logic       resp_err,
`endif
   output logic [15:0] ops_done
);

   typedef enum logic [1:0] {S_IDLE, S_EXEC, S_RESP} state_t;

   state_t      state_q;
   logic        prio1_q;
   logic [7:0]  a_q;
   logic [7:0]  b_q;
   logic [3:0]  op_q;
   logic        id_q;
   logic        resp_valid_q;
   logic        resp_id_q;
   logic [8:0]  resp_data_q;
   logic [15:0] ops_q;
   logic [15:0] ops_d;
   logic        gnt0_d;
   logic        gnt1_d;
   logic        is_idle;
   logic        is_exec;
`ifdef ALU_ARBITER_ERR_EN
   logic        err_q;
`endif

   assign is_idle = (state_q == S_IDLE);
   assign is_exec = (state_q == S_EXEC);

   // prio1_q set means requester 1 wins a tie; rst_n gating keeps ready low during reset
   assign gnt0_d = is_idle & rst_n & req0_valid & (~req1_valid | ~prio1_q);
   assign gnt1_d = is_idle & rst_n & req1_valid & (~req0_valid |  prio1_q);
   assign ops_d  = ops_q + 16'd1;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= S_IDLE;
         prio1_q      <= 1'b0;
         a_q          <= '0;
         b_q          <= '0;
         op_q         <= IDLE_OP;
         id_q         <= 1'b0;
         resp_valid_q <= 1'b0;
         resp_id_q    <= 1'b0;
         resp_data_q  <= '0;
         ops_q        <= '0;
`ifdef ALU_ARBITER_ERR_EN
         err_q        <= 1'b0;
`endif
      end else begin
         case (state_q)
            S_IDLE: begin
               if (gnt0_d | gnt1_d) begin
                  a_q     <= gnt1_d ? req1_a  : req0_a;
                  b_q     <= gnt1_d ? req1_b  : req0_b;
                  op_q    <= gnt1_d ? req1_op : req0_op;
                  id_q    <= gnt1_d;
                  prio1_q <= gnt0_d;
                  state_q <= S_EXEC;
               end
            end
            S_EXEC: begin
               resp_data_q  <= alu_z;
               resp_id_q    <= id_q;
               resp_valid_q <= 1'b1;
`ifdef ALU_ARBITER_ERR_EN
               err_q        <= ((op_q == 4'd2) && (b_q == 8'd0)) || (op_q >= 4'd10);
`endif
               state_q      <= S_RESP;
            end
            S_RESP: begin
               if (resp_ready) begin
                  resp_valid_q <= 1'b0;
                  ops_q        <= ops_d;
                  state_q      <= S_IDLE;
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign req0_ready = gnt0_d;
   assign req1_ready = gnt1_d;
   assign alu_a      = is_exec ? a_q  : 8'd0;
   assign alu_b      = is_exec ? b_q  : 8'd0;
   assign alu_op     = is_exec ? op_q : IDLE_OP;
   assign resp_valid = resp_valid_q;
   assign resp_id    = resp_id_q;
   assign resp_data  = resp_data_q;
   assign ops_done   = ops_q;
`ifdef ALU_ARBITER_ERR_EN
   assign resp_err   = err_q;
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
// tb/tb_alu_arbiter.sv - bench for alu_arbiter: timestamp model, per-cycle compare, directed and random stimulus
module tb_alu_arbiter;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        req0_valid, req1_valid;
   logic        req0_ready, req1_ready;
   logic [7:0]  req0_a, req0_b, req1_a, req1_b;
   logic [3:0]  req0_op, req1_op;
   logic [7:0]  alu_a, alu_b;
   logic [3:0]  alu_op;
   logic [8:0]  alu_z;
   logic        resp_valid, resp_id, resp_ready;
   logic [8:0]  resp_data;
   logic [15:0] ops_done;
`ifdef ALU_ARBITER_ERR_EN
   logic        resp_err;
`endif

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   alu_arbiter dut (
      .clk(clk), .rst_n(rst_n),
      .req0_valid(req0_valid), .req0_ready(req0_ready),
      .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
      .req1_valid(req1_valid), .req1_ready(req1_ready),
      .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
      .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_z(alu_z),
      .resp_valid(resp_valid), .resp_id(resp_id), .resp_data(resp_data),
      .resp_ready(resp_ready),
`ifdef ALU_ARBITER_ERR_EN
      .resp_err(resp_err),
`endif
      .ops_done(ops_done)
   );

   function automatic logic [8:0] alu_fn(input logic [7:0] a, input logic [7:0] b, input logic [3:0] op);
      logic [8:0] ea, eb, prod;
      ea = {1'b0, a};
      eb = {1'b0, b};
      prod = ea * eb;
      case (op)
         4'd0: return ea + eb;
         4'd1: return ea - eb;
         4'd2: return (b == 8'd0) ? 9'd0 : {1'b0, a / b};
         4'd3: return prod;
         4'd4: return ea & eb;
         4'd5: return ea | eb;
         4'd6: return ea ^ eb;
         4'd7: return {1'b0, ~a};
         4'd8: return {a, 1'b0};
         4'd9: return {1'b0, a >> 1};
         default: return 9'd0;
      endcase
   endfunction

   always_comb alu_z = alu_fn(alu_a, alu_b, alu_op);

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Model: a transaction is pending from its accept; m_age 0 is the execute cycle, >=1 the response cycles
   logic       m_pend = 1'b0;
   logic       m_age = 1'b0;
   logic       m_last = 1'b1;
   logic [7:0] m_a = '0, m_b = '0;
   logic [3:0] m_op = '0;
   logic       m_id = 1'b0;
   logic [15:0] m_ops = '0;
   logic       e_rdy0, e_rdy1, e_exec, e_rvalid;

   always_comb begin
      e_rdy0   = !m_pend && (rst_n === 1'b1) && req0_valid && (!req1_valid || m_last);
      e_rdy1   = !m_pend && (rst_n === 1'b1) && req1_valid && (!req0_valid || !m_last);
      e_exec   = m_pend && !m_age;
      e_rvalid = m_pend && m_age;
   end

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_pend <= 1'b0;
         m_age  <= 1'b0;
         m_last <= 1'b1;
         m_ops  <= '0;
      end else if (e_rdy0 || e_rdy1) begin
         m_pend <= 1'b1;
         m_age  <= 1'b0;
         m_a    <= e_rdy1 ? req1_a  : req0_a;
         m_b    <= e_rdy1 ? req1_b  : req0_b;
         m_op   <= e_rdy1 ? req1_op : req0_op;
         m_id   <= e_rdy1;
         m_last <= e_rdy1;
      end else if (m_pend) begin
         if (!m_age) m_age <= 1'b1;
         else if (resp_ready) begin
            m_pend <= 1'b0;
            m_ops  <= m_ops + 16'd1;
         end
      end
   end

   always @(negedge clk) begin
      chk("req0_ready", req0_ready, e_rdy0);
      chk("req1_ready", req1_ready, e_rdy1);
      chk("resp_valid", resp_valid, e_rvalid);
      chk("alu_a", alu_a, e_exec ? m_a : 8'd0);
      chk("alu_b", alu_b, e_exec ? m_b : 8'd0);
      chk("alu_op", alu_op, e_exec ? m_op : 4'hF);
      chk("ops_done", ops_done, m_ops);
      if (e_rvalid) begin
         chk("resp_data", resp_data, alu_fn(m_a, m_b, m_op));
         chk("resp_id", resp_id, m_id);
`ifdef ALU_ARBITER_ERR_EN
         chk("resp_err", resp_err, ((m_op == 4'd2) && (m_b == 8'd0)) || (m_op >= 4'd10));
`endif
      end
   end

   task automatic set_req(input int r, input logic [7:0] a, input logic [7:0] b, input logic [3:0] op);
      if (r == 0) begin
         req0_a = a; req0_b = b; req0_op = op; req0_valid = 1'b1;
      end else begin
         req1_a = a; req1_b = b; req1_op = op; req1_valid = 1'b1;
      end
   endtask

   task automatic wait_accept(input int r);
      for (int i = 0; i < 30; i++) begin
         @(negedge clk);
         if ((r == 0 && req0_ready) || (r == 1 && req1_ready)) begin
            @(posedge clk);
            #1;
            if (r == 0) req0_valid = 1'b0;
            else        req1_valid = 1'b0;
            return;
         end
      end
      chk("accept_timeout", 32'd1, 32'd0);
   endtask

   task automatic wait_resp(output logic [8:0] d, output logic id, output int lat);
      d = '0; id = 1'b0; lat = -1;
      for (int i = 0; i < 30; i++) begin
         @(negedge clk);
         if (resp_valid) begin
            d = resp_data; id = resp_id; lat = i + 1;
            return;
         end
      end
      chk("resp_timeout", 32'd1, 32'd0);
   endtask

   task automatic do_reset();
      @(posedge clk); #1 rst_n = 1'b0;
      @(posedge clk); #1 rst_n = 1'b1;
   endtask

   logic [8:0] d;
   logic       id;
   int         lat;

   initial begin
      rst_n = 1'b0;
      req0_valid = 0; req1_valid = 0; resp_ready = 1'b1;
      req0_a = 0; req0_b = 0; req0_op = 0; req1_a = 0; req1_b = 0; req1_op = 0;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      @(negedge clk);
      chk("rst_resp_valid", resp_valid, 32'd0);
      chk("rst_resp_data", resp_data, 32'd0);
      chk("rst_resp_id", resp_id, 32'd0);
      chk("rst_ops_done", ops_done, 32'd0);
      chk("rst_alu_op", alu_op, 32'hF);

      @(posedge clk); #1 set_req(0, 8'd200, 8'd100, 4'd0);
      wait_accept(0);
      wait_resp(d, id, lat);
      chk("add_latency", lat, 32'd2);
      chk("add_data", d, 32'd300);
      chk("add_id", id, 32'd0);
      @(posedge clk); @(negedge clk);
      chk("add_ops_done", ops_done, 32'd1);

      do_reset();
      set_req(0, 8'd15, 8'd17, 4'd3);
      set_req(1, 8'd5, 8'd3, 4'd1);
      wait_accept(0);
      wait_resp(d, id, lat);
      chk("tie_first_data", d, 32'd255);
      chk("tie_first_id", id, 32'd0);
      wait_accept(1);
      wait_resp(d, id, lat);
      chk("tie_second_data", d, 32'd2);
      chk("tie_second_id", id, 32'd1);

      @(posedge clk); #1 resp_ready = 1'b0;
      set_req(0, 8'd40, 8'd2, 4'd0);
      wait_accept(0);
      set_req(1, 8'd1, 8'd1, 4'd0);
      wait_resp(d, id, lat);
      chk("stall_data", d, 32'd42);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("stall_valid", resp_valid, 32'd1);
         chk("stall_data_hold", resp_data, 32'd42);
         chk("stall_ready0", req0_ready, 32'd0);
         chk("stall_ready1", req1_ready, 32'd0);
      end
      @(posedge clk); #1 resp_ready = 1'b1;
      wait_accept(1);
      wait_resp(d, id, lat);
      chk("post_stall_data", d, 32'd2);

      @(posedge clk); #1 set_req(0, 8'd9, 8'd0, 4'd2);
      wait_accept(0);
      wait_resp(d, id, lat);
      chk("div0_data", d, 32'd0);
`ifdef ALU_ARBITER_ERR_EN
      chk("div0_err", resp_err, 32'd1);
`endif
      @(posedge clk); #1 set_req(0, 8'd7, 8'd3, 4'hC);
      wait_accept(0);
      wait_resp(d, id, lat);
      chk("opC_data", d, 32'd0);
`ifdef ALU_ARBITER_ERR_EN
      chk("opC_err", resp_err, 32'd1);
`endif

      @(posedge clk); #1 set_req(0, 8'd1, 8'd2, 4'd0);
      wait_accept(0);
      #1 rst_n = 1'b0;
      @(negedge clk);
      chk("rst_exec_valid", resp_valid, 32'd0);
      @(posedge clk); #1 rst_n = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("rst_exec_no_resp", resp_valid, 32'd0);
      end
      chk("rst_exec_ops", ops_done, 32'd0);
      @(posedge clk); #1 set_req(0, 8'd3, 8'd4, 4'd0);
      wait_accept(0);
      wait_resp(d, id, lat);
      chk("after_rst_latency", lat, 32'd2);
      chk("after_rst_data", d, 32'd7);

      for (int i = 0; i < 3000; i++) begin
         @(posedge clk); #1;
         req0_valid = ($urandom_range(0, 2) != 0);
         req1_valid = ($urandom_range(0, 2) != 0);
         req0_a = 8'($urandom); req0_b = 8'($urandom); req0_op = 4'($urandom_range(0, 15));
         req1_a = 8'($urandom); req1_b = 8'($urandom); req1_op = 4'($urandom_range(0, 15));
         resp_ready = ($urandom_range(0, 3) != 0);
      end
      @(posedge clk); #1;
      req0_valid = 0; req1_valid = 0; resp_ready = 1'b1;
      repeat (6) @(posedge clk);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
